dma_priority_arbiter: RTL

Request/priority resolver for the 8237A-style DMA controller. It samples the four DREQ lines and the software request register, and requests the bus from the 8086 via HRQ/HLDA. It then selects one channel by fixed or rotating priority and drives DACK, and hands the active channel to timing control until that block signals end of service.

---
 rtl/dma_priority_arbiter_if.sv | 34 +++
 rtl/dma_priority_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter_if.sv
// Bus-side signals of the DMA request/priority resolver: channel requests,
// command bits, CPU hold handshake and the acknowledge/service outputs.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic [NUM_CH-1:0] MASK;
    logic [NUM_CH-1:0] SW_REQ;
    logic              ROT_PRI;
    logic              CTRL_DISABLE;
    logic              DREQ_SENSE_LOW;
    logic              DACK_SENSE_HIGH;
    logic              XFER_DONE;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [CH_W-1:0]   ACTIVE_CH;
    logic              SVC_VALID;

    // Arbiter side.
    modport master (
        input  DREQ, HLDA, MASK, SW_REQ, ROT_PRI, CTRL_DISABLE,
               DREQ_SENSE_LOW, DACK_SENSE_HIGH, XFER_DONE,
        output HRQ, DACK, ACTIVE_CH, SVC_VALID
    );

    // CPU / register file / timing-control side.
    modport slave (
        output DREQ, HLDA, MASK, SW_REQ, ROT_PRI, CTRL_DISABLE,
               DREQ_SENSE_LOW, DACK_SENSE_HIGH, XFER_DONE,
        input  HRQ, DACK, ACTIVE_CH, SVC_VALID
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style request/priority resolver: synchronizes DREQ, negotiates the bus
// with HRQ/HLDA and grants one channel by fixed or rotating priority.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input logic                    CLK,
    input logic                    RESET,
    dma_priority_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SVC,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] dreq_p0;
    logic [NUM_CH-1:0] dreq_p1;
    logic [NUM_CH-1:0] eff;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   active_ch;
    logic [CH_W-1:0]   rot_top;
    logic [CH_W-1:0]   winner;
    logic              hrq;
    logic              svc_valid;

    // Scan from base upward with wraparound; first requesting channel wins.
    function automatic logic [CH_W-1:0] pick_winner(
        input logic [NUM_CH-1:0] req,
        input logic [CH_W-1:0]   base
    );
        logic [CH_W-1:0] idx;
        logic            found;
        pick_winner = base;
        found       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = base + CH_W'(i);
            if (!found && req[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    always_comb begin
        eff = ((dreq_p1 ^ {NUM_CH{bus.DREQ_SENSE_LOW}}) & ~bus.MASK) | bus.SW_REQ;
    end

    // rot_top holds the highest-priority channel: the one after the last serviced.
    assign winner = pick_winner(eff, bus.ROT_PRI ? rot_top : '0);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            hrq       <= 1'b0;
            grant     <= '0;
            svc_valid <= 1'b0;
            active_ch <= '0;
            rot_top   <= '0;
            dreq_p0   <= {NUM_CH{bus.DREQ_SENSE_LOW}};
            dreq_p1   <= {NUM_CH{bus.DREQ_SENSE_LOW}};
        end else begin
            // stage p0 -> p1: two-flop DREQ synchronizer
            dreq_p0 <= bus.DREQ;
            dreq_p1 <= dreq_p0;

            case (state)
                S_IDLE: begin
                    if ((|eff) && !bus.CTRL_DISABLE) begin
                        hrq   <= 1'b1;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.HLDA) begin
                        if (|eff) begin
                            grant     <= {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
                            active_ch <= winner;
                            svc_valid <= 1'b1;
                            state     <= S_SVC;
                        end else begin
                            hrq   <= 1'b0;
                            state <= S_RELEASE;
                        end
                    end else if (!(|eff)) begin
                        hrq   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_SVC: begin
                    // End of service wins over a simultaneous CPU revoke.
                    if (bus.XFER_DONE) begin
                        grant     <= '0;
                        svc_valid <= 1'b0;
                        hrq       <= 1'b0;
                        rot_top   <= active_ch + 1'b1;
                        state     <= S_RELEASE;
                    end else if (!bus.HLDA) begin
                        grant     <= '0;
                        svc_valid <= 1'b0;
                        hrq       <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    hrq <= 1'b0;
                    if (!bus.HLDA) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HRQ       = hrq;
    assign bus.DACK      = bus.DACK_SENSE_HIGH ? grant : ~grant;
    assign bus.ACTIVE_CH = active_ch;
    assign bus.SVC_VALID = svc_valid;

endmodule
